// File: rtl/dp_types_pkg.sv
// Shared datapath types: stage-register mode selector and the packed stage payloads
// carried between the five pipeline stages.
package dp_types_pkg;

  typedef enum logic {MODE_PLAIN, MODE_SKID} pipemode_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        wb_en;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] st_data;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        wb_en;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        wb_en;
  } mem_wb_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1'b1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register with valid/ready handshake, flush and stall/bubble counters.
// MODE_SKID holds up to two entries so that in_ready comes straight from a flop.
module pipe_stage_buf
  import dp_types_pkg::*;
#(
  parameter int unsigned      WIDTH   = $bits(if_id_t),
  parameter pipemode_t        MODE    = MODE_SKID,
  parameter int unsigned      CNT_W   = 16,
  parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  input  logic             clr_cnt
);

  logic             r_main_v, r_skid_v, r_in_ready;
  logic [WIDTH-1:0] r_main_d, r_skid_d;
  logic             w_main_v_d, w_skid_v_d, w_in_ready_d;
  logic [WIDTH-1:0] w_main_d_d, w_skid_d_d;
  logic             w_in_xfer, w_out_xfer;
  logic             w_stall_inc, w_bubble_inc, w_kill;

  assign in_ready   = (MODE == MODE_SKID) ? r_in_ready : (out_ready | ~r_main_v);
  assign out_valid  = r_main_v;
  assign out_data   = r_main_d;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_main_v & out_ready;

  always_comb begin
    w_main_v_d = r_main_v;
    w_skid_v_d = r_skid_v;
    w_main_d_d = r_main_d;
    w_skid_d_d = r_skid_d;
    if (flush) begin
      w_main_v_d = 1'b0;
      w_skid_v_d = 1'b0;
      w_main_d_d = NOP_VAL;
      w_skid_d_d = NOP_VAL;
    end else if (MODE == MODE_PLAIN) begin
      if (w_in_xfer) begin
        w_main_v_d = 1'b1;
        w_main_d_d = in_data;
      end else if (w_out_xfer) begin
        w_main_v_d = 1'b0;
        w_main_d_d = NOP_VAL;
      end
    end else begin
      case ({r_main_v, r_skid_v})
        2'b00: begin
          if (w_in_xfer) begin
            w_main_v_d = 1'b1;
            w_main_d_d = in_data;
          end
        end
        2'b10: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_d_d = in_data;
          end else if (w_out_xfer) begin
            w_main_v_d = 1'b0;
            w_main_d_d = NOP_VAL;
          end else if (w_in_xfer) begin
            w_skid_v_d = 1'b1;
            w_skid_d_d = in_data;
          end
        end
        2'b11: begin
          // in_ready is low here, so only the downstream side can move
          if (w_out_xfer) begin
            w_main_d_d = r_skid_d;
            w_skid_v_d = 1'b0;
            w_skid_d_d = NOP_VAL;
          end
        end
        default: begin
          w_skid_v_d = 1'b0;
        end
      endcase
    end
    w_in_ready_d = ~w_skid_v_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_main_d   <= NOP_VAL;
      r_skid_d   <= NOP_VAL;
      r_in_ready <= 1'b1;
    end else begin
      r_main_v   <= w_main_v_d;
      r_skid_v   <= w_skid_v_d;
      r_main_d   <= w_main_d_d;
      r_skid_d   <= w_skid_d_d;
      r_in_ready <= w_in_ready_d;
    end
  end

  // A flush kills something unless the only held entry leaves downstream that same cycle
  assign w_kill       = flush & (r_skid_v | (r_main_v & ~out_ready));
  assign w_stall_inc  = r_main_v & ~out_ready;
  assign w_bubble_inc = ~r_main_v | w_kill;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (w_stall_inc),
    .clr  (clr_cnt),
    .count(stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (w_bubble_inc),
    .clr  (clr_cnt),
    .count(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid instances (16- and 4-bit counters) and a plain instance,
// checked against queue-based reference models.
module tb_pipe_stage_buf;
  import dp_types_pkg::*;

  localparam int unsigned W = 32;

  logic CLK = 1'b0;
  logic nRST = 1'b1;

  logic         s_flush, s_in_valid, s_out_ready, s_clr;
  logic [W-1:0] s_in_data;
  logic         s_in_ready, s_out_valid, c_in_ready, c_out_valid;
  logic [W-1:0] s_out_data, c_out_data;
  logic [15:0]  s_stall, s_bubble;
  logic [3:0]   c_stall, c_bubble;

  logic         p_flush, p_in_valid, p_out_ready, p_clr;
  logic [W-1:0] p_in_data;
  logic         p_in_ready, p_out_valid;
  logic [W-1:0] p_out_data;
  logic [15:0]  p_stall, p_bubble;

  pipe_stage_buf #(.WIDTH(W), .MODE(MODE_SKID), .CNT_W(16), .NOP_VAL('0)) dut_s (
    .CLK(CLK), .nRST(nRST), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .stall_cnt(s_stall), .bubble_cnt(s_bubble), .clr_cnt(s_clr)
  );

  pipe_stage_buf #(.WIDTH(W), .MODE(MODE_SKID), .CNT_W(4), .NOP_VAL('0)) dut_c (
    .CLK(CLK), .nRST(nRST), .flush(s_flush), .in_valid(s_in_valid), .in_ready(c_in_ready),
    .in_data(s_in_data), .out_valid(c_out_valid), .out_ready(s_out_ready),
    .out_data(c_out_data), .stall_cnt(c_stall), .bubble_cnt(c_bubble), .clr_cnt(s_clr)
  );

  pipe_stage_buf #(.WIDTH(W), .MODE(MODE_PLAIN), .CNT_W(16), .NOP_VAL('0)) dut_p (
    .CLK(CLK), .nRST(nRST), .flush(p_flush), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_data(p_in_data), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_data(p_out_data), .stall_cnt(p_stall), .bubble_cnt(p_bubble), .clr_cnt(p_clr)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: each stage is a FIFO of held payloads (capacity 2 skid, 1 plain)
  logic [W-1:0] ms_q[$];
  logic [W-1:0] mp_q[$];
  int unsigned  ms_stall, ms_bub, mp_stall, mp_bub;

  function automatic int unsigned sat(input int unsigned raw, input int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 32'd1;
    return (raw > mx) ? mx : raw;
  endfunction

  function automatic logic [W-1:0] s_head();
    return (ms_q.size() > 0) ? ms_q[0] : '0;
  endfunction

  function automatic logic [W-1:0] p_head();
    return (mp_q.size() > 0) ? mp_q[0] : '0;
  endfunction

  task automatic model_reset();
    ms_q.delete();
    mp_q.delete();
    ms_stall = 0; ms_bub = 0; mp_stall = 0; mp_bub = 0;
  endtask

  task automatic tick();
    bit s_ix, s_ox, s_st, s_bu, p_ix, p_ox, p_st, p_bu;
    logic [W-1:0] sd, pd;
    bit sf, pf, sc, pc;
    s_ox = (ms_q.size() > 0) && s_out_ready;
    s_ix = s_in_valid && (ms_q.size() < 2) && !s_flush;
    s_st = (ms_q.size() > 0) && !s_out_ready;
    s_bu = (ms_q.size() == 0) || (s_flush && (ms_q.size() - int'(s_ox) > 0));
    p_ox = (mp_q.size() > 0) && p_out_ready;
    p_ix = p_in_valid && ((mp_q.size() == 0) || p_out_ready) && !p_flush;
    p_st = (mp_q.size() > 0) && !p_out_ready;
    p_bu = (mp_q.size() == 0) || (p_flush && (mp_q.size() - int'(p_ox) > 0));
    sd = s_in_data; pd = p_in_data; sf = s_flush; pf = p_flush; sc = s_clr; pc = p_clr;
    @(posedge CLK);
    #1;
    if (!nRST) begin
      model_reset();
    end else begin
      if (s_ox) void'(ms_q.pop_front());
      if (sf) ms_q.delete();
      else if (s_ix) ms_q.push_back(sd);
      if (p_ox) void'(mp_q.pop_front());
      if (pf) mp_q.delete();
      else if (p_ix) mp_q.push_back(pd);
      ms_stall = sc ? 0 : ms_stall + int'(s_st);
      ms_bub   = sc ? 0 : ms_bub + int'(s_bu);
      mp_stall = pc ? 0 : mp_stall + int'(p_st);
      mp_bub   = pc ? 0 : mp_bub + int'(p_bu);
    end
  endtask

  task automatic idle_inputs();
    s_flush = 0; s_in_valid = 0; s_out_ready = 0; s_clr = 0; s_in_data = '0;
    p_flush = 0; p_in_valid = 0; p_out_ready = 0; p_clr = 0; p_in_data = '0;
  endtask

  task automatic test_reset();
    s_in_valid = 1; s_in_data = 32'hDEAD; p_in_valid = 1; p_in_data = 32'hDEAD;
    s_out_ready = 1; p_out_ready = 1;
    nRST = 0;
    tick();
    tick();
    n_cmp++;
    if ({s_out_valid, s_out_data} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL reset_s_out: got %b/%h want 0/0", s_out_valid, s_out_data);
    end
    n_cmp++;
    if ({s_stall, s_bubble, c_stall, c_bubble} !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", s_stall, s_bubble);
    end
    n_cmp++;
    if ({p_out_valid, p_out_data} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL reset_p_out: got %b/%h want 0/0", p_out_valid, p_out_data);
    end
    idle_inputs();
    nRST = 1;
    #1;
    n_cmp++;
    if ({s_in_ready, p_in_ready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_in_ready: got %b/%b want 1/1", s_in_ready, p_in_ready);
    end
  endtask

  task automatic test_stream();
    s_out_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      s_in_valid = 1; s_in_data = W'(i);
      tick();
      n_cmp++;
      if ({s_out_valid, s_out_data, s_in_ready} !== {1'b1, W'(i), 1'b1}) begin
        n_fail++;
        $display("FAIL stream_%0d: got v=%b d=%h r=%b want v=1 d=%h r=1",
                 i, s_out_valid, s_out_data, s_in_ready, W'(i));
      end
    end
    s_in_valid = 0;
    tick();
    n_cmp++;
    if ({s_out_valid, s_out_data} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL stream_drain: got %b/%h want 0/0", s_out_valid, s_out_data);
    end
  endtask

  task automatic test_stall();
    s_clr = 1; tick(); s_clr = 0;
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 32'hA0A0;
    tick();
    s_in_data = 32'hB0B0;
    tick();
    n_cmp++;
    if ({s_in_ready, s_out_valid, s_out_data} !== {1'b0, 1'b1, 32'hA0A0}) begin
      n_fail++;
      $display("FAIL stall_full: got r=%b v=%b d=%h want r=0 v=1 d=a0a0",
               s_in_ready, s_out_valid, s_out_data);
    end
    s_in_data = 32'hBAD;
    repeat (3) tick();
    s_in_valid = 0; s_out_ready = 1;
    tick();
    n_cmp++;
    if ({s_out_valid, s_out_data} !== {1'b1, 32'hB0B0}) begin
      n_fail++; $display("FAIL stall_second: got %b/%h want 1/b0b0", s_out_valid, s_out_data);
    end
    tick();
    n_cmp++;
    if ({s_out_valid, s_out_data} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL stall_empty: got %b/%h want 0/0", s_out_valid, s_out_data);
    end
    n_cmp++;
    if ((s_stall !== 16'd4) || (32'(s_stall) !== sat(ms_stall, 16))) begin
      n_fail++; $display("FAIL stall_cnt: got %0d want 4 (model %0d)", s_stall, ms_stall);
    end
  endtask

  task automatic test_flush();
    logic [15:0] b0;
    s_out_ready = 0; s_in_valid = 1; s_in_data = 32'hA2;
    tick();
    s_in_data = 32'hB2;
    tick();
    b0 = s_bubble;
    s_flush = 1; s_in_data = 32'hC0C0;
    tick();
    s_flush = 0; s_in_valid = 0;
    n_cmp++;
    if ({s_out_valid, s_out_data, s_in_ready} !== {1'b0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_full: got v=%b d=%h r=%b want v=0 d=0 r=1",
               s_out_valid, s_out_data, s_in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (s_out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_idle_%0d: got v=%b d=%h want v=0", i, s_out_valid, s_out_data);
      end
    end
    n_cmp++;
    if ((s_bubble !== b0 + 16'd4) || (32'(s_bubble) !== sat(ms_bub, 16))) begin
      n_fail++; $display("FAIL flush_bubble: got %0d want %0d", s_bubble, b0 + 16'd4);
    end
    s_out_ready = 1; s_in_valid = 1; s_in_data = 32'hD0;
    tick();
    s_in_valid = 0; b0 = s_bubble; s_flush = 1;
    tick();
    s_flush = 0;
    n_cmp++;
    if ((s_bubble !== b0) || (s_out_valid !== 1'b0)) begin
      n_fail++; $display("FAIL flush_xfer: got bubble %0d v=%b want %0d v=0", s_bubble, s_out_valid, b0);
    end
  endtask

  task automatic test_saturation();
    s_clr = 1; tick(); s_clr = 0;
    s_out_ready = 0; s_in_valid = 1; s_in_data = 32'h55;
    tick();
    s_in_valid = 0;
    repeat (20) tick();
    n_cmp++;
    if ((c_stall !== 4'd15) || (s_stall !== 16'd20)) begin
      n_fail++; $display("FAIL sat_stall: got c=%0d s=%0d want c=15 s=20", c_stall, s_stall);
    end
    s_clr = 1;
    tick();
    s_clr = 0;
    n_cmp++;
    if ({c_stall, s_stall} !== '0) begin
      n_fail++; $display("FAIL sat_clr: got c=%0d s=%0d want 0/0", c_stall, s_stall);
    end
    s_out_ready = 1;
    tick();
  endtask

  task automatic test_plain_comb();
    p_out_ready = 1; p_in_valid = 1; p_in_data = 32'h1111;
    tick();
    p_in_valid = 0; p_out_ready = 0;
    #1;
    n_cmp++;
    if (p_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL plain_ready_lo: got %b want 0", p_in_ready);
    end
    p_out_ready = 1;
    #1;
    n_cmp++;
    if (p_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL plain_ready_hi: got %b want 1", p_in_ready);
    end
    p_out_ready = 0; p_in_valid = 1; p_in_data = 32'h2222;
    tick();
    n_cmp++;
    if ({p_out_valid, p_out_data} !== {1'b1, 32'h1111}) begin
      n_fail++; $display("FAIL plain_hold: got %b/%h want 1/1111", p_out_valid, p_out_data);
    end
    p_out_ready = 1;
    tick();
    p_in_valid = 0;
    tick();
    n_cmp++;
    if ({p_out_valid, p_out_data} !== {p_q_valid(), p_head()}) begin
      n_fail++; $display("FAIL plain_drain: got %b/%h want %b/%h", p_out_valid, p_out_data,
                         p_q_valid(), p_head());
    end
  endtask

  function automatic logic p_q_valid();
    return mp_q.size() > 0;
  endfunction

  task automatic test_midreset();
    s_out_ready = 0; s_in_valid = 1; s_in_data = 32'h77;
    p_out_ready = 0; p_in_valid = 1; p_in_data = 32'h88;
    tick();
    idle_inputs();
    #2 nRST = 0;
    #1;
    n_cmp++;
    if ({s_out_valid, s_out_data, p_out_valid, p_out_data} !== '0) begin
      n_fail++; $display("FAIL midreset_async: got s=%b/%h p=%b/%h want all 0",
                         s_out_valid, s_out_data, p_out_valid, p_out_data);
    end
    model_reset();
    tick();
    nRST = 1;
    #1;
    n_cmp++;
    if ({s_in_ready, s_stall, s_bubble} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL midreset_after: got r=%b st=%0d bu=%0d want 1/0/0",
                         s_in_ready, s_stall, s_bubble);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      s_in_valid  = ($urandom_range(0, 3) != 0);
      s_in_data   = $urandom;
      s_out_ready = ($urandom_range(0, 9) < 7);
      s_flush     = ($urandom_range(0, 19) == 0);
      s_clr       = ($urandom_range(0, 49) == 0);
      p_in_valid  = ($urandom_range(0, 2) != 0);
      p_in_data   = $urandom;
      p_out_ready = ($urandom_range(0, 9) < 6);
      p_flush     = ($urandom_range(0, 24) == 0);
      p_clr       = ($urandom_range(0, 49) == 0);
      #1;
      n_cmp++;
      if (p_in_ready !== ((mp_q.size() == 0) || p_out_ready)) begin
        n_fail++; $display("FAIL rnd_p_ready cyc %0d: got %b", i, p_in_ready);
      end
      tick();
      n_cmp++;
      if ({s_out_valid, s_out_data, s_in_ready} !==
          {ms_q.size() > 0, s_head(), ms_q.size() < 2}) begin
        n_fail++; $display("FAIL rnd_s_out cyc %0d: got %b/%h/%b want %b/%h/%b", i, s_out_valid,
                           s_out_data, s_in_ready, ms_q.size() > 0, s_head(), ms_q.size() < 2);
      end
      n_cmp++;
      if ({c_out_valid, c_out_data, c_in_ready} !== {s_q_valid(), s_head(), ms_q.size() < 2}) begin
        n_fail++; $display("FAIL rnd_c_out cyc %0d: got %b/%h want %b/%h", i, c_out_valid,
                           c_out_data, s_q_valid(), s_head());
      end
      n_cmp++;
      if ((32'(s_stall) !== sat(ms_stall, 16)) || (32'(s_bubble) !== sat(ms_bub, 16)) ||
          (32'(c_stall) !== sat(ms_stall, 4)) || (32'(c_bubble) !== sat(ms_bub, 4))) begin
        n_fail++; $display("FAIL rnd_s_cnt cyc %0d: got %0d/%0d c %0d/%0d want raw %0d/%0d",
                           i, s_stall, s_bubble, c_stall, c_bubble, ms_stall, ms_bub);
      end
      n_cmp++;
      if ({p_out_valid, p_out_data} !== {p_q_valid(), p_head()}) begin
        n_fail++; $display("FAIL rnd_p_out cyc %0d: got %b/%h want %b/%h", i, p_out_valid,
                           p_out_data, p_q_valid(), p_head());
      end
      n_cmp++;
      if ((32'(p_stall) !== sat(mp_stall, 16)) || (32'(p_bubble) !== sat(mp_bub, 16))) begin
        n_fail++; $display("FAIL rnd_p_cnt cyc %0d: got %0d/%0d want %0d/%0d",
                           i, p_stall, p_bubble, mp_stall, mp_bub);
      end
    end
    idle_inputs();
  endtask

  function automatic logic s_q_valid();
    return ms_q.size() > 0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    model_reset();
    #1 nRST = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_saturation();
    test_plain_comb();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
